reg_op_sequencer: RTL and testbench
===================================

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 16 registers x 8 bits (4-bit addresses).
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with ports as listed below.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  operation request valid.
REQ-006 op_ready  output  1  block can accept a request.
REQ-007 op_code  input  3  operation select.
REQ-008 op_rd  input  4  destination register index.
REQ-009 op_rs1  input  4  source register 1 index.
REQ-010 op_rs2  input  4  source register 2 index.
REQ-011 reg1_read_addr  output  4  register-file read port 1 address.
REQ-012 reg2_read_addr  output  4  register-file read port 2 address.
REQ-013 reg1_read_data_in  input  8  register-file read port 1 data (combinational).
REQ-014 reg2_read_data_in  input  8  register-file read port 2 data (combinational).
REQ-015 reg_write_address_out  output  4  register-file write address.
REQ-016 reg_write_data_out  output  8  register-file write data.
REQ-017 reg_write_enable  output  1  register-file write strobe, one cycle.
REQ-018 result  output  8  last computed result, held.
REQ-019 flag_c  output  1  carry/borrow of last operation, held.
REQ-020 flag_z  output  1  last result == 0, held.
REQ-021 done  output  1  one-cycle pulse at operation completion.

Function
REQ-022 FSM states: IDLE, READ, EXEC, WRITE; op_ready SHALL be 1 only in IDLE.
REQ-023 IDLE: on op_valid && op_ready at a clock edge, latch op_code/rd/rs1/rs2 and go to READ; otherwise stay in IDLE.
REQ-024 READ (1 cycle): reg1/reg2_read_addr SHALL equal the latched rs1/rs2; operands are captured at the end of the cycle; next state is EXEC.
REQ-025 Read addresses SHALL hold their last values outside READ.
REQ-026 EXEC (1 cycle): result, flag_c and flag_z are registered at the end of the cycle; next state is WRITE.
REQ-027 Ops: 000 ADD a+b, C=bit8; 001 SUB a-b, C=(a<b); 010 AND; 011 OR; 100 XOR; 101 SHL a<<1, C=a[7]; 110 SHR a>>1, C=a[0]; 111 CMP (as SUB, no write-back).
REQ-028 Logic ops (AND/OR/XOR) SHALL clear C; all results SHALL be truncated modulo 256.
REQ-029 WRITE (1 cycle): done=1; reg_write_address_out=rd and reg_write_data_out=result; reg_write_enable=1 unless op is CMP; next state is IDLE.
REQ-030 Latency SHALL be 3 cycles: with accept edge at cycle 0, cycle 1 is READ, cycle 2 is EXEC, cycle 3 is WRITE, and op_ready=1 in cycle 4.
REQ-031 rd may equal rs1 and/or rs2; register 0 SHALL be an ordinary writable register.
REQ-032 The write-back completes before the next READ, so back-to-back dependent ops SHALL see the updated value with no hazard logic.
REQ-033 op_valid asserted outside IDLE SHALL be ignored; the requester holds it until op_ready is seen.
REQ-034 reg_write_enable and done SHALL be 0 in every state except WRITE.

Reset
REQ-035 On reset low, the FSM SHALL go to IDLE immediately; all outputs become 0 except op_ready=1; latched fields are cleared.
REQ-036 Reset asserted during READ, EXEC or WRITE SHALL abort the operation with no write strobe after assertion and no done pulse.
REQ-037 After reset release, the first accepted request SHALL behave as in REQ-030.

Verification
REQ-038 R3=0x0F, R4=0xF1, ADD rd=5 -> cycle 3: write_enable=1, addr=5, data=0x00; C=1, Z=1; done pulse.
REQ-039 R1=0x10, R2=0x20, SUB rd=1 rs1=1 rs2=2 -> writes 0xF0 to R1, C=1, Z=0; then ADD R1+R2 back-to-back -> writes 0x10.
REQ-040 CMP of R6=0x33 with R7=0x33 -> Z=1, C=0, done=1, reg_write_enable stays 0 throughout.
REQ-041 SHL on R8=0x81 -> writes 0x02, C=1; SHR on 0x81 -> 0x40, C=1.
REQ-042 op_valid pulsed during EXEC -> ignored; held until IDLE -> accepted exactly once.
REQ-043 Reset asserted in EXEC -> next cycle shows IDLE, op_ready=1, no write strobe, outputs 0.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// Four-state register-file operation sequencer: accepts one ALU request, reads two
// operands, executes, then writes the result back to the destination register.
module reg_op_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [3:0] op_rd,
  input  logic [3:0] op_rs1,
  input  logic [3:0] op_rs2,
  output logic [3:0] reg1_read_addr,
  output logic [3:0] reg2_read_addr,
  input  logic [7:0] reg1_read_data_in,
  input  logic [7:0] reg2_read_data_in,
  output logic [3:0] reg_write_address_out,
  output logic [7:0] reg_write_data_out,
  output logic       reg_write_enable,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  state_t     state_q, state_d;
  logic       accept;
  logic [2:0] code_q;
  logic [3:0] rd_q;
  logic [3:0] raddr1_q, raddr2_q;
  logic [7:0] a_q, b_q;
  logic [7:0] result_q;
  logic       c_q, z_q;
  logic [7:0] alu_res;
  logic       alu_c;

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (code_q)
      OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB,
      OP_CMP: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = {a_q[6:0], 1'b0};
        alu_c   = a_q[7];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[7:1]};
        alu_c   = a_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      code_q   <= 3'b000;
      rd_q     <= 4'h0;
      raddr1_q <= 4'h0;
      raddr2_q <= 4'h0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // The read addresses double as the latched source fields, so they hold outside READ.
      if (accept) begin
        code_q   <= op_code;
        rd_q     <= op_rd;
        raddr1_q <= op_rs1;
        raddr2_q <= op_rs2;
      end
      if (state_q == READ) begin
        a_q <= reg1_read_data_in;
        b_q <= reg2_read_data_in;
      end
      if (state_q == EXEC) begin
        result_q <= alu_res;
        c_q      <= alu_c;
        z_q      <= (alu_res == 8'h00);
      end
    end
  end

  assign op_ready              = (state_q == IDLE);
  assign reg1_read_addr        = raddr1_q;
  assign reg2_read_addr        = raddr2_q;
  assign reg_write_address_out = rd_q;
  assign reg_write_data_out    = result_q;
  assign reg_write_enable      = (state_q == WRITE) && (code_q != OP_CMP);
  assign done                  = (state_q == WRITE);
  assign result                = result_q;
  assign flag_c                = c_q;
  assign flag_z                = z_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: external register file, arithmetic reference model,
// scoreboard queue filled at issue time and drained by a done-driven monitor.
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [3:0] op_rd, op_rs1, op_rs2;
  logic [3:0] reg1_read_addr, reg2_read_addr;
  logic [7:0] reg1_read_data_in, reg2_read_data_in;
  logic [3:0] reg_write_address_out;
  logic [7:0] reg_write_data_out;
  logic       reg_write_enable;
  logic [7:0] result;
  logic       flag_c, flag_z, done;

  reg_op_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .op_valid              (op_valid),
    .op_ready              (op_ready),
    .op_code               (op_code),
    .op_rd                 (op_rd),
    .op_rs1                (op_rs1),
    .op_rs2                (op_rs2),
    .reg1_read_addr        (reg1_read_addr),
    .reg2_read_addr        (reg2_read_addr),
    .reg1_read_data_in     (reg1_read_data_in),
    .reg2_read_data_in     (reg2_read_data_in),
    .reg_write_address_out (reg_write_address_out),
    .reg_write_data_out    (reg_write_data_out),
    .reg_write_enable      (reg_write_enable),
    .result                (result),
    .flag_c                (flag_c),
    .flag_z                (flag_z),
    .done                  (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment register file; poke port lets the bench preload values while idle.
  logic [7:0] rf [16];
  logic [7:0] mdl [16];
  logic       poke_en = 1'b0;
  logic [3:0] poke_addr = 4'h0;
  logic [7:0] poke_data = 8'h00;

  always @(posedge clk) begin
    if (poke_en) rf[poke_addr] <= poke_data;
    else if (reg_write_enable) rf[reg_write_address_out] <= reg_write_data_out;
  end
  assign reg1_read_data_in = rf[reg1_read_addr];
  assign reg2_read_data_in = rf[reg2_read_addr];

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       c;
    logic       z;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else
      $display("[TB] ok %s = %0h", name, got);
  endtask

  // Reference arithmetic: returns {carry, result}.
  function automatic logic [8:0] ref_op(input logic [2:0] code, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, r, c;
    ai = a; bi = b; r = 0; c = 0;
    case (code)
      3'd0: begin r = (ai + bi) % 256; c = (ai + bi >= 256) ? 1 : 0; end
      3'd1, 3'd7: begin r = (ai - bi + 256) % 256; c = (ai < bi) ? 1 : 0; end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: begin r = (ai * 2) % 256; c = (ai >= 128) ? 1 : 0; end
      3'd6: begin r = ai / 2; c = ai % 2; end
      default: ;
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic poke(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    mdl[addr] = data;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one request; returns at the negedge of the READ cycle.
  task automatic issue(input logic [2:0] code, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input bit early, input bit push);
    int n;
    logic [8:0] cr;
    exp_t e;
    n = 0;
    if (early) begin
      op_valid = 1'b1; op_code = code; op_rd = rd; op_rs1 = rs1; op_rs2 = rs2;
    end else
      @(negedge clk);
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    op_valid = 1'b1; op_code = code; op_rd = rd; op_rs1 = rs1; op_rs2 = rs2;
    @(negedge clk);
    op_valid = 1'b0;
    chk("ready_low_in_read", {31'd0, op_ready}, 32'd0);
    if (push) begin
      cr     = ref_op(code, mdl[rs1], mdl[rs2]);
      e.we   = (code != 3'd7);
      e.addr = rd;
      e.data = cr[7:0];
      e.c    = cr[8];
      e.z    = (cr[7:0] == 8'h00);
      e.cyc  = cyc;
      sb.push_back(e);
      if (e.we) mdl[rd] = cr[7:0];
      $display("[TB] issue op=%0d rd=%0d rs1=%0d rs2=%0d exp_data=%02h c=%0b z=%0b",
               code, rd, rs1, rs2, e.data, e.c, e.z);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((!op_ready || sb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("idle_reached", {31'd0, op_ready}, 32'd1);
  endtask

  // Monitor: every done pulse is checked against the oldest scoreboard entry.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (prev_done) chk("ready_after_write", {31'd0, op_ready}, 32'd1);
      if (reg_write_enable && !done) begin
        tests++; fails++;
        $display("FAIL we_outside_write got=1 exp=0");
      end
      if (done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done got=1 exp=0");
        end else begin
          e = sb.pop_front();
          chk("wb_enable", {31'd0, reg_write_enable}, {31'd0, e.we});
          chk("wb_addr", {28'd0, reg_write_address_out}, {28'd0, e.addr});
          chk("wb_data_flags", {20'd0, reg_write_data_out, result, flag_c, flag_z, 2'b00},
              {20'd0, e.data, e.data, e.c, e.z, 2'b00});
          // Accept edge precedes the READ negedge; WRITE is visible two edges later.
          chk("latency", cyc - e.cyc, 32'd2);
        end
      end
      prev_done = done;
    end else
      prev_done = 1'b0;
  end

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_code = 3'd0;
    op_rd = 4'd0; op_rs1 = 4'd0; op_rs2 = 4'd0;
    #1;
    chk("reset_ready", {31'd0, op_ready}, 32'd1);
    chk("reset_outputs", {8'd0, result, reg_write_data_out, reg_write_address_out, flag_c, flag_z, done, reg_write_enable},
        32'd0);
    chk("reset_raddr", {24'd0, reg1_read_addr, reg2_read_addr}, 32'd0);
    for (int i = 0; i < 16; i++) poke(i[3:0], 8'($urandom_range(0, 255)));
    @(negedge clk);
    reset = 1'b1;

    // ADD wrapping to zero
    poke(4'd3, 8'h0F); poke(4'd4, 8'hF1);
    issue(3'd0, 4'd5, 4'd3, 4'd4, 1'b0, 1'b1);
    wait_idle();
    chk("add_wrap_r5", {24'd0, rf[5]}, 32'h00);
    chk("add_wrap_flags", {30'd0, flag_c, flag_z}, 32'b11);

    // SUB in place, then dependent ADD back-to-back
    poke(4'd1, 8'h10); poke(4'd2, 8'h20);
    issue(3'd1, 4'd1, 4'd1, 4'd2, 1'b0, 1'b1);
    issue(3'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1);
    wait_idle();
    chk("sub_r1", {24'd0, rf[1]}, 32'hF0);
    chk("dep_add_r3", {24'd0, rf[3]}, 32'h10);

    // CMP equal: no write-back
    poke(4'd6, 8'h33); poke(4'd7, 8'h33);
    issue(3'd7, 4'd6, 4'd6, 4'd7, 1'b0, 1'b1);
    wait_idle();
    chk("cmp_flags", {30'd0, flag_c, flag_z}, 32'b01);
    chk("cmp_r6_kept", {24'd0, rf[6]}, 32'h33);

    // Shifts
    poke(4'd8, 8'h81);
    issue(3'd5, 4'd9, 4'd8, 4'd0, 1'b0, 1'b1);
    issue(3'd6, 4'd10, 4'd8, 4'd0, 1'b0, 1'b1);
    wait_idle();
    chk("shl_r9", {24'd0, rf[9]}, 32'h02);
    chk("shr_r10", {24'd0, rf[10]}, 32'h40);

    // op_valid pulsed only during EXEC is ignored
    issue(3'd4, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; op_rd = 4'd11; op_rs1 = 4'd1; op_rs2 = 4'd1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pulse_ignored", {31'd0, op_ready}, 32'd1);
    chk("pulse_no_pending", sb.size(), 32'd0);

    // op_valid raised during EXEC and held is accepted once in IDLE
    issue(3'd2, 4'd12, 4'd1, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    issue(3'd3, 4'd13, 4'd12, 4'd9, 1'b1, 1'b1);
    wait_idle();

    // Reset asserted in EXEC aborts the operation
    issue(3'd0, 4'd14, 4'd1, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'd0, op_ready}, 32'd1);
    chk("abort_outputs", {8'd0, result, reg_write_data_out, reg_write_address_out, flag_c, flag_z, done, reg_write_enable},
        32'd0);
    @(negedge clk);
    chk("abort_idle_next", {30'd0, op_ready, reg_write_enable}, 32'b10);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    for (int i = 0; i < 16; i++) chk($sformatf("rf_final_%0d", i), {24'd0, rf[i]}, {24'd0, mdl[i]});
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
